// File: rtl/mem_io_if.sv
// mem_io_if: CPU byte-bus plus host UART-side signals for mem_io_responder.
//   master : CPU/host side (drives address, write data, tx_ready, rx_*)
//   slave  : responder side (drives mem_din, TX FIFO head, status flags)
interface mem_io_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;
  logic        tx_overflow;

  modport master (
    output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready,
           program_stop, tx_overflow
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready,
           program_stop, tx_overflow
  );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: responder end of the CPU byte-wide memory bus.
//   - On-chip RAM (2**RAM_ADDR_WIDTH bytes), one-cycle registered read.
//   - I/O window at mem_a[17:16]==2'b11:
//       0x30000 rd: RX byte (pops host source via rx_ready), wr: TX push (0x00 dropped)
//       0x30004 rd: cycle_cnt[7:0] + snapshot, 0x30005..7 rd: snapshot bytes
//       0x30004 wr: set program_stop, push 0x00 to TX
//   - TX FIFO (TX_FIFO_DEPTH, power of two >= 4), first-word-fall-through,
//     io_buffer_full at DEPTH-2, sticky tx_overflow on dropped bytes.
// Ports:
//   clk_in  : system clock
//   rst_in  : asynchronous active-low reset
//   bus     : mem_io_if.slave (CPU bus, TX/RX host side, status)
// Build option: MEM_IO_RX_EN -- when defined the RX port is live; otherwise
//   rx_data/rx_valid are ignored, rx_ready is 0 and 0x30000 reads return 0.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH  = 8
) (
  input  logic     clk_in,
  input  logic     rst_in,
  mem_io_if.slave  bus
);

  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [17:0] IO_RX   = 18'h30000;
  localparam logic [17:0] IO_CNT0 = 18'h30004;
  localparam logic [17:0] IO_CNT1 = 18'h30005;
  localparam logic [17:0] IO_CNT2 = 18'h30006;
  localparam logic [17:0] IO_CNT3 = 18'h30007;

  // ---------------- decode ----------------
  logic [17:0] a18;
  logic        is_io, wr, rd_rx, rd_cnt0;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic        unused_hi;

  assign a18      = bus.mem_a[17:0];
  assign wr       = bus.mem_wr;
  assign is_io    = (a18[17:16] == 2'b11);
  assign rd_rx    = !wr && (a18 == IO_RX);
  assign rd_cnt0  = !wr && (a18 == IO_CNT0);
  assign ram_addr = bus.mem_a[RAM_ADDR_WIDTH-1:0];
  assign unused_hi = ^bus.mem_a[31:18];

  // ---------------- RX port ----------------
  logic       rx_hit;
  logic [7:0] rx_byte;
`ifdef MEM_IO_RX_EN
  assign rx_hit  = rd_rx && bus.rx_valid;
  assign rx_byte = bus.rx_data;
`else
  logic unused_rx;
  assign unused_rx = ^{bus.rx_data, bus.rx_valid, rd_rx};
  assign rx_hit  = 1'b0;
  assign rx_byte = 8'h00;
`endif
  // Gated by reset so the strobe is quiet while the block is held in reset.
  assign bus.rx_ready = rx_hit && rst_in;

  // ---------------- RAM (not reset) ----------------
  logic [7:0] ram [2**RAM_ADDR_WIDTH];

  always_ff @(posedge clk_in) begin
    if (wr && !is_io) ram[ram_addr] <= bus.mem_dout;
  end

  // ---------------- cycle counter / snapshot ----------------
  logic [31:0] cycle_cnt, snap;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt <= '0;
      snap      <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (rd_cnt0) snap <= cycle_cnt;
    end
  end

  // ---------------- read data ----------------
  logic [7:0] rd_byte;

  always_comb begin
    rd_byte = 8'h00;
    if (is_io) begin
      case (a18)
        IO_RX:   rd_byte = rx_hit ? rx_byte : 8'h00;
        IO_CNT0: rd_byte = cycle_cnt[7:0];
        IO_CNT1: rd_byte = snap[15:8];
        IO_CNT2: rd_byte = snap[23:16];
        IO_CNT3: rd_byte = snap[31:24];
        default: rd_byte = 8'h00;
      endcase
    end else begin
      rd_byte = ram[ram_addr];
    end
  end

  // mem_din holds its value across write cycles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)  bus.mem_din <= 8'h00;
    else if (!wr) bus.mem_din <= rd_byte;
  end

  // ---------------- program stop ----------------
  logic stop_wr;
  assign stop_wr = wr && (a18 == IO_CNT0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)      bus.program_stop <= 1'b0;
    else if (stop_wr) bus.program_stop <= 1'b1;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [TX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, full, accept;
  logic [7:0]    push_byte;

  // The stop marker 0x00 bypasses the zero filter that applies to 0x30000.
  assign push      = stop_wr || (wr && (a18 == IO_RX) && (bus.mem_dout != 8'h00));
  assign push_byte = stop_wr ? 8'h00 : bus.mem_dout;
  assign full      = (count == CW'(TX_FIFO_DEPTH));
  assign pop       = bus.tx_valid && bus.tx_ready;
  // When full, a same-cycle pop frees the slot the push writes into.
  assign accept    = push && (!full || pop);

  assign bus.tx_valid       = (count != '0);
  assign bus.tx_data        = tx_mem[rd_ptr];
  assign bus.io_buffer_full = (count >= CW'(TX_FIFO_DEPTH - 2));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < TX_FIFO_DEPTH; i++) tx_mem[i] <= 8'h00;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.tx_overflow <= 1'b0;
    end else begin
      if (accept) begin
        tx_mem[wr_ptr] <= push_byte;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) bus.tx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  mem_io_if bus();

  mem_io_responder #(.RAM_ADDR_WIDTH(17), .TX_FIFO_DEPTH(8)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

`ifdef MEM_IO_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic [31:0] edges;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference cycle index: edges since reset release.
  always @(posedge clk_in or negedge rst_in)
    if (!rst_in) edges <= 32'd0;
    else         edges <= edges + 32'd1;

  // Read scoreboard: entries pushed right after the sampling edge are due
  // at the following negedge.
  always @(negedge clk_in)
    while (exp_q.size() != 0)
      chk(tag_q.pop_front(), {24'h0, bus.mem_din}, {24'h0, exp_q.pop_front()});

  task automatic idle_in();
    bus.mem_wr   = 1'b0;
    bus.mem_a    = 32'h0003_0008;
    bus.mem_dout = 8'h00;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_in); @(negedge clk_in); end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus.mem_wr = 1'b1; bus.mem_a = a; bus.mem_dout = d;
    @(posedge clk_in);
    @(negedge clk_in);
    idle_in();
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e, input string tag);
    bus.mem_wr = 1'b0; bus.mem_a = a;
    @(posedge clk_in);
    exp_q.push_back(e); tag_q.push_back(tag);
    @(negedge clk_in);
    idle_in();
  endtask

  task automatic chk_all_reset(input string pfx);
    chk({pfx, "_mem_din"},  {24'h0, bus.mem_din}, 32'h0);
    chk({pfx, "_tx_valid"}, {31'h0, bus.tx_valid}, 32'h0);
    chk({pfx, "_tx_data"},  {24'h0, bus.tx_data}, 32'h0);
    chk({pfx, "_rx_ready"}, {31'h0, bus.rx_ready}, 32'h0);
    chk({pfx, "_buf_full"}, {31'h0, bus.io_buffer_full}, 32'h0);
    chk({pfx, "_stop"},     {31'h0, bus.program_stop}, 32'h0);
    chk({pfx, "_ovf"},      {31'h0, bus.tx_overflow}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c;
    logic [7:0]  drain [8];
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    idle_in();
    #12;
    chk_all_reset("rst");
    @(negedge clk_in); rst_in = 1'b1;

    // RAM round trip, including the top byte of RAM
    wr(32'h0000_0123, 8'hA5);
    rd(32'h0000_0123, 8'hA5, "ram_123");
    wr(32'h0001_FFFF, 8'h3C);
    rd(32'h0001_FFFF, 8'h3C, "ram_1ffff");
    rd(32'h0000_0123, 8'hA5, "ram_123_again");

    // TX path: zero byte is filtered
    wr(32'h0003_0000, 8'h48);
    wr(32'h0003_0000, 8'h00);
    wr(32'h0003_0000, 8'h69);
    chk("tx_valid_2", {31'h0, bus.tx_valid}, 32'h1);
    chk("tx_head_48", {24'h0, bus.tx_data}, 32'h48);
    chk("tx_nfull_2", {31'h0, bus.io_buffer_full}, 32'h0);
    bus.tx_ready = 1'b1;
    chk("tx_see_48", {24'h0, bus.tx_data}, 32'h48);
    cyc(1);
    chk("tx_see_69", {24'h0, bus.tx_data}, 32'h69);
    chk("tx_valid_1", {31'h0, bus.tx_valid}, 32'h1);
    cyc(1);
    chk("tx_empty", {31'h0, bus.tx_valid}, 32'h0);
    bus.tx_ready = 1'b0;

    // Back-pressure
    for (int n = 1; n <= 8; n++) begin
      wr(32'h0003_0000, 8'(n));
      chk($sformatf("bp_full_%0d", n), {31'h0, bus.io_buffer_full}, (n >= 6) ? 32'h1 : 32'h0);
    end
    chk("bp_no_ovf_8", {31'h0, bus.tx_overflow}, 32'h0);
    bus.tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h0A);          // push + pop while full
    bus.tx_ready = 1'b0;
    chk("bp_pp_ovf", {31'h0, bus.tx_overflow}, 32'h0);
    chk("bp_pp_full", {31'h0, bus.io_buffer_full}, 32'h1);
    chk("bp_pp_head", {24'h0, bus.tx_data}, 32'h02);
    wr(32'h0003_0000, 8'h0B);          // dropped
    chk("bp_ovf", {31'h0, bus.tx_overflow}, 32'h1);
    drain = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_v%0d", i), {31'h0, bus.tx_valid}, 32'h1);
      chk($sformatf("drain_d%0d", i), {24'h0, bus.tx_data}, {24'h0, drain[i]});
      cyc(1);
    end
    bus.tx_ready = 1'b0;
    chk("drain_empty", {31'h0, bus.tx_valid}, 32'h0);
    chk("ovf_sticky", {31'h0, bus.tx_overflow}, 32'h1);

    // Counter snapshot
    cyc(3);
    c = edges;
    rd(32'h0003_0004, c[7:0],   "cnt_b0");
    rd(32'h0003_0005, c[15:8],  "cnt_b1");
    rd(32'h0003_0006, c[23:16], "cnt_b2");
    rd(32'h0003_0007, c[31:24], "cnt_b3");

    // Unmapped I/O
    rd(32'h0003_0008, 8'h00, "io_other_rd");
    wr(32'h0003_0001, 8'h33);
    chk("io_other_wr", {31'h0, bus.tx_valid}, 32'h0);

    // Program stop
    wr(32'h0003_0004, 8'h55);
    chk("stop_set", {31'h0, bus.program_stop}, 32'h1);
    chk("stop_txv", {31'h0, bus.tx_valid}, 32'h1);
    chk("stop_txd", {24'h0, bus.tx_data}, 32'h00);
    bus.tx_ready = 1'b1; cyc(1); bus.tx_ready = 1'b0;
    chk("stop_drained", {31'h0, bus.tx_valid}, 32'h0);

    // RX with data available
    bus.rx_valid = 1'b1; bus.rx_data = 8'h7A;
    bus.mem_wr = 1'b0; bus.mem_a = 32'h0003_0000;
    #1 chk("rx_ready_on", {31'h0, bus.rx_ready}, {31'h0, RX_EN});
    @(posedge clk_in);
    exp_q.push_back(RX_EN ? 8'h7A : 8'h00); tag_q.push_back("rx_data");
    @(negedge clk_in);
    bus.rx_valid = 1'b0; idle_in();
    #1 chk("rx_ready_off", {31'h0, bus.rx_ready}, 32'h0);
    // RX without data
    bus.mem_a = 32'h0003_0000;
    #1 chk("rx_ready_idle", {31'h0, bus.rx_ready}, 32'h0);
    @(posedge clk_in);
    exp_q.push_back(8'h00); tag_q.push_back("rx_none");
    @(negedge clk_in);
    idle_in();

    // Async reset mid-burst
    wr(32'h0003_0000, 8'h41);
    wr(32'h0003_0000, 8'h42);
    rd(32'h0000_0123, 8'hA5, "pre_rst_rd");
    bus.mem_a = 32'h0000_0123;
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    exp_q.delete(); tag_q.delete();
    #1 chk_all_reset("arst");
    @(negedge clk_in); rst_in = 1'b1;
    idle_in();
    rd(32'h0003_0004, 8'h00, "cnt_restart");
    chk("arst_txv_after", {31'h0, bus.tx_valid}, 32'h0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
